// File: rtl/kyo_win_addr_gen.sv
// Win-pose sprite address generator: vsync-paced frame sequencer plus a
// one-cycle hit test that turns the scan position into a sprite ROM address.
module kyo_win_addr_gen #(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int NUM_FRAMES  = 4,
    parameter int FRAME_TICKS = 8
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        start,
    input  logic        clear,
    input  logic        mirror,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [13:0] rom_address,
    output logic        sprite_hit,
    output logic        busy,
    output logic        done
);

    localparam int XW = $clog2(SPR_W);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [13:0]   FRAME_SZ   = 14'(SPR_W * SPR_H);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

    state_t        state;
    logic [FW-1:0] frame_idx;
    logic [TW-1:0] tick_cnt;
    logic [13:0]   frame_base;
    logic          vsync_q;
    logic          vs_fall;

    logic [10:0]   dx_p0;
    logic [10:0]   dy_p0;
    logic [XW-1:0] col_p0;
    logic          inside_p0;
    logic [13:0]   addr_p1;
    logic          hit_p1;

    // Row offset is a shift because SPR_W is a power of two; the frame
    // offset is accumulated in frame_base so no multiply is needed.
    function automatic logic [13:0] calc_addr(input logic [13:0]   base,
                                              input logic [10:0]   row,
                                              input logic [XW-1:0] col);
        logic [24:0] row_off;
        row_off = {14'd0, row} << XW;
        return base + row_off[13:0] + 14'(col);
    endfunction

    assign vs_fall = vsync_q & ~vsync;
    assign busy    = (state == PLAY);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            frame_idx  <= '0;
            tick_cnt   <= '0;
            frame_base <= '0;
            vsync_q    <= 1'b1;
            done       <= 1'b0;
        end else begin
            vsync_q <= vsync;
            done    <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                frame_idx  <= '0;
                tick_cnt   <= '0;
                frame_base <= '0;
            end else if (start) begin
                state      <= PLAY;
                frame_idx  <= '0;
                tick_cnt   <= '0;
                frame_base <= '0;
            end else if (state == PLAY && vs_fall) begin
                if (tick_cnt == LAST_TICK) begin
                    tick_cnt <= '0;
                    if (frame_idx == LAST_FRAME) begin
                        state <= HOLD;
                        done  <= 1'b1;
                    end else begin
                        frame_idx  <= frame_idx + 1'b1;
                        frame_base <= frame_base + FRAME_SZ;
                    end
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 0: hit test at 11 bits so a sprite hanging off the right edge never wraps
    assign dx_p0     = {1'b0, draw_x} - {1'b0, pos_x};
    assign dy_p0     = {1'b0, draw_y} - {1'b0, pos_y};
    assign inside_p0 = (draw_x >= pos_x) & (dx_p0 < 11'(SPR_W)) &
                       (draw_y >= pos_y) & (dy_p0 < 11'(SPR_H)) &
                       (state != IDLE);
    assign col_p0    = mirror ? ~dx_p0[XW-1:0] : dx_p0[XW-1:0];

    // Stage 1: registered address and hit for the ROM read on the next negedge
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_p1 <= '0;
            hit_p1  <= 1'b0;
        end else if (inside_p0) begin
            addr_p1 <= calc_addr(frame_base, dy_p0, col_p0);
            hit_p1  <= 1'b1;
        end else begin
            addr_p1 <= '0;
            hit_p1  <= 1'b0;
        end
    end

    assign rom_address = addr_p1;
    assign sprite_hit  = hit_p1;

endmodule

// File: tb/tb_kyo_win_addr_gen.sv
// Bench for kyo_win_addr_gen: edge-counting reference model checked every
// negedge, plus directed pixels with literal expected addresses.
module tb_kyo_win_addr_gen;

    localparam int SPR_W = 64, SPR_H = 64, NUM_FRAMES = 4, FRAME_TICKS = 8;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vsync = 1'b1, start = 1'b0, clear = 1'b0, mirror = 1'b0;
    logic [9:0]  pos_x = 10'd100, pos_y = 10'd100;
    logic [9:0]  draw_x = 10'd100, draw_y = 10'd100;
    logic [13:0] rom_address;
    logic        sprite_hit, busy, done;

    int errs = 0;
    int checks = 0;

    kyo_win_addr_gen #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES), .FRAME_TICKS(FRAME_TICKS)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .vsync(vsync), .start(start),
        .clear(clear), .mirror(mirror), .pos_x(pos_x), .pos_y(pos_y),
        .draw_x(draw_x), .draw_y(draw_y), .rom_address(rom_address),
        .sprite_hit(sprite_hit), .busy(busy), .done(done)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: animation position is just the count of vsync falls
    // seen since the last start; mode 0=hidden, 1=playing, 2=holding.
    int m_mode = 0, m_falls = 0;
    logic m_vs_prev = 1'b1;
    int exp_hit = 0, exp_addr = 0, exp_done = 0;
    int mdx, mdy, mcol, mframe;
    logic mfall;

    always @(posedge vga_clk) begin
        if (!reset_n) begin
            m_mode = 0; m_falls = 0; m_vs_prev = 1'b1;
            exp_hit = 0; exp_addr = 0; exp_done = 0;
        end else begin
            mdx = int'(draw_x) - int'(pos_x);
            mdy = int'(draw_y) - int'(pos_y);
            mframe = m_falls / FRAME_TICKS;
            if (mframe > NUM_FRAMES - 1) mframe = NUM_FRAMES - 1;
            if (m_mode != 0 && mdx >= 0 && mdx < SPR_W && mdy >= 0 && mdy < SPR_H) begin
                mcol = mirror ? (SPR_W - 1 - mdx) : mdx;
                exp_hit  = 1;
                exp_addr = (mframe * SPR_W * SPR_H + mdy * SPR_W + mcol) % 16384;
            end else begin
                exp_hit = 0; exp_addr = 0;
            end
            mfall = m_vs_prev & ~vsync;
            exp_done = 0;
            if (clear) begin
                m_mode = 0; m_falls = 0;
            end else if (start) begin
                m_mode = 1; m_falls = 0;
            end else if (m_mode == 1 && mfall) begin
                m_falls++;
                if (m_falls == NUM_FRAMES * FRAME_TICKS) begin
                    m_mode = 2; exp_done = 1;
                end
            end
            m_vs_prev = vsync;
        end
    end

    always @(negedge vga_clk) begin
        chk("model_hit", int'(sprite_hit), exp_hit);
        chk("model_addr", int'(rom_address), exp_addr);
        chk("model_busy", int'(busy), int'(m_mode == 1));
        chk("model_done", int'(done), exp_done);
    end

    task automatic pix(input int x, input int y);
        @(negedge vga_clk);
        draw_x = 10'(x); draw_y = 10'(y);
        @(posedge vga_clk); #1;
    endtask

    task automatic vs_pulse();
        @(negedge vga_clk); vsync = 1'b0;
        @(negedge vga_clk); vsync = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge vga_clk); start = 1'b1;
        @(negedge vga_clk); start = 1'b0;
    endtask

    task automatic settle();
        @(posedge vga_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_addr", int'(rom_address), 0);
        chk("reset_hit", int'(sprite_hit), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge vga_clk); reset_n = 1'b1;

        pix(100, 100);
        chk("idle_hit", int'(sprite_hit), 0);
        chk("idle_addr", int'(rom_address), 0);

        pulse_start();
        pix(105, 103);
        chk("play_hit", int'(sprite_hit), 1);
        chk("play_addr", int'(rom_address), 197);
        chk("play_busy", int'(busy), 1);
        pix(163, 100);
        chk("right_col", int'(rom_address), 63);
        pix(164, 100);
        chk("past_right", int'(sprite_hit), 0);
        pix(99, 100);
        chk("left_of", int'(sprite_hit), 0);
        @(negedge vga_clk); mirror = 1'b1;
        pix(105, 103);
        chk("mirror_addr", int'(rom_address), 250);
        @(negedge vga_clk); mirror = 1'b0;

        pix(105, 103);
        repeat (8) vs_pulse();
        settle();
        chk("frame1_addr", int'(rom_address), 4293);
        repeat (23) vs_pulse();
        settle();
        chk("pre_hold_busy", int'(busy), 1);
        chk("frame3_addr", int'(rom_address), 12485);
        @(negedge vga_clk); vsync = 1'b0;
        settle();
        chk("done_pulse", int'(done), 1);
        chk("hold_busy", int'(busy), 0);
        @(negedge vga_clk); vsync = 1'b1;
        settle();
        chk("done_once", int'(done), 0);
        chk("hold_addr", int'(rom_address), 12485);
        repeat (3) vs_pulse();
        settle();
        chk("hold_stays", int'(rom_address), 12485);

        pulse_start();
        settle();
        chk("restart_addr", int'(rom_address), 197);
        repeat (16) vs_pulse();
        settle();
        chk("frame2_addr", int'(rom_address), 8389);
        @(negedge vga_clk); vsync = 1'b0; start = 1'b1;
        @(negedge vga_clk); vsync = 1'b1; start = 1'b0;
        settle();
        chk("coincide_addr", int'(rom_address), 197);
        repeat (7) vs_pulse();
        settle();
        chk("tick_reset_7", int'(rom_address), 197);
        vs_pulse();
        settle();
        chk("tick_reset_8", int'(rom_address), 4293);

        @(negedge vga_clk); clear = 1'b1; start = 1'b1;
        @(negedge vga_clk); clear = 1'b0; start = 1'b0;
        settle();
        chk("clear_hit", int'(sprite_hit), 0);
        chk("clear_busy", int'(busy), 0);

        pulse_start();
        @(negedge vga_clk); pos_x = 10'd1000;
        pix(1023, 100);
        chk("edge_hit", int'(sprite_hit), 1);
        chk("edge_addr", int'(rom_address), 23);
        pix(5, 100);
        chk("no_wrap", int'(sprite_hit), 0);

        pix(1023, 100);
        @(negedge vga_clk); #1;
        reset_n = 1'b0;
        #1;
        chk("async_addr", int'(rom_address), 0);
        chk("async_hit", int'(sprite_hit), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge vga_clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/kyo_win_addr_gen.md
Name: kyo_win_addr_gen

Overview:
- Upstream address generator for the Kyo win-pose sprite renderer.
- Consumes the VGA scan position (draw_x/draw_y), the sprite screen position and a start strobe.
- Runs a multi-frame win animation paced by vertical sync.
- Produces the registered 14-bit rom_address and an in-sprite hit flag for the palette/ROM stage.

Parameters:
- SPR_W, 64: sprite frame width in pixels (power of two).
- SPR_H, 64: sprite frame height in pixels.
- NUM_FRAMES, 4: animation frames stored back-to-back in ROM; NUM_FRAMES*SPR_W*SPR_H must be ≤ 16384.
- FRAME_TICKS, 8: vsync periods each animation frame is held.

Ports:
- vga_clk  input  1  pixel clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- vsync  input  1  VGA vertical sync, active-low; its falling edge is the frame boundary.
- start  input  1  one-cycle pulse: (re)start the win animation.
- clear  input  1  one-cycle pulse: return to IDLE (sprite hidden).
- mirror  input  1  1 = horizontally flipped sprite (facing left).
- pos_x  input  10  screen X of the sprite's top-left pixel.
- pos_y  input  10  screen Y of the sprite's top-left pixel.
- draw_x  input  10  current scan column.
- draw_y  input  10  current scan row.
- rom_address  output  14  ROM word address for the current pixel (registered).
- sprite_hit  output  1  1 when the current pixel lies inside the visible sprite (registered).
- busy  output  1  1 while in PLAY.
- done  output  1  one-cycle pulse when the last frame has been held FRAME_TICKS vsyncs.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; frame_idx=0; tick_cnt=0; vsync_q=1; rom_address=0; sprite_hit=0; busy=0; done=0.
- Frame boundary: vsync_q registers vsync each cycle. vs_fall = vsync_q & ~vsync.
- FSM:
  - IDLE: start → PLAY with frame_idx=0, tick_cnt=0.
  - PLAY: on vs_fall, tick_cnt++. When tick_cnt==FRAME_TICKS-1 at a vs_fall, tick_cnt←0 and frame_idx++. If frame_idx==NUM_FRAMES-1, go to HOLD instead and pulse done for one cycle; frame_idx stays NUM_FRAMES-1.
  - HOLD: last frame displayed indefinitely. start → PLAY (restart at frame 0). clear → IDLE.
  - clear from PLAY → IDLE.
- Priority (same cycle): clear > start > vs_fall. start in PLAY restarts at frame 0, tick 0, and the coincident vs_fall is ignored.
- frame_idx changes only at vs_fall, so the frame cannot tear mid-screen.
- Hit test (combinational, then registered):
  - dx = draw_x - pos_x and dy = draw_y - pos_y, computed at 11 bits.
  - inside = (draw_x ≥ pos_x) & (dx < SPR_W) & (draw_y ≥ pos_y) & (dy < SPR_H) & (state≠IDLE).
  - pos_x+SPR_W beyond 1023 must not wrap: the 11-bit compare handles it.
- Column select: col = mirror ? SPR_W-1-dx : dx.
- Address: rom_address = frame_idx*SPR_W*SPR_H + dy*SPR_W + col, truncated to 14 bits. Use shifts; no multipliers.
- Miss case: rom_address=0 and sprite_hit=0.
- Latency: rom_address and sprite_hit are valid exactly 1 vga_clk after the draw_x/draw_y they correspond to. The downstream stage reads ROM on the following negedge.
- busy is combinational from state (state==PLAY).
- done is registered; it is the single pulse on the PLAY→HOLD transition.
- Reset asserted mid-animation forces IDLE immediately; outputs go to reset values without waiting for a clock.

Test Plan:
- Reset then idle scan: draw_x=100, draw_y=100, pos=(100,100), no start → sprite_hit=0, rom_address=0.
- start, pos=(100,100), mirror=0, draw=(105,103) → next cycle sprite_hit=1, rom_address=3*64+5=197. Edges:
  - draw=(163,100) → 63.
  - draw=(164,100) → hit=0.
  - draw=(99,100) → hit=0.
- mirror=1, draw=(105,103) → rom_address=3*64+58=250.
- PLAY pacing: apply 8 vsync falling edges → frame_idx=1; the same pixel gives 4096+197=4293. After 32 edges total, done pulses once, busy=0, HOLD; the pixel gives 12288+197=12485, and further vsyncs leave it unchanged.
- start coincident with a vs_fall during PLAY at frame 2 → frame 0, tick 0. clear and start together → IDLE, hit=0.
- pos_x=1000, draw_x=1023, draw_y in range → hit=1, col=23, no wrap. Async reset mid-PLAY → all outputs 0 before the next clock edge.
